synchronous_fifo: RTL and testbench

//  Single-clock FIFO buffering DATA_WIDTH-bit words between producer and consumer
//  in the same clock domain. Provides write/read enables, a registered read-data

---
 rtl/fifo_pkg.sv | 12 +
 rtl/synchronous_fifo.sv | 76 +++++++
 tb/tb_synchronous_fifo.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults for the single-clock FIFO and the pointer-width helper.
package fifo_pkg;

  localparam int DEFAULT_DEPTH      = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;

  // One extra bit beyond the address lets full and empty be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/synchronous_fifo.sv
// Single-clock in-order FIFO with registered read data and
// pointer-derived full/empty flags.
module synchronous_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]         w_ptr_reg;
  logic [PW-1:0]         r_ptr_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;

  logic write_accept;
  logic read_accept;

  // Flags come straight from the registered pointers, so they
  // settle one edge after the operation that changed them.
  assign empty = (w_ptr_reg == r_ptr_reg);
  assign full  = (w_ptr_reg[AW-1:0] == r_ptr_reg[AW-1:0]) &&
                 (w_ptr_reg[AW] != r_ptr_reg[AW]);

  assign write_accept = w_en && !full;
  assign read_accept  = r_en && !empty;

  assign data_out = data_out_reg;

  // Storage is never cleared; reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (!rst && write_accept) begin
      mem[w_ptr_reg[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_reg <= '0;
    end else if (write_accept) begin
      w_ptr_reg <= w_ptr_reg + PTR_ONE;
    end
  end

  // No write-to-read bypass: a read only ever sees words already stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr_reg    <= '0;
      data_out_reg <= '0;
    end else if (read_accept) begin
      r_ptr_reg    <= r_ptr_reg + PTR_ONE;
      data_out_reg <= mem[r_ptr_reg[AW-1:0]];
    end
  end

`ifdef FIFO_ASSERTIONS
  a_no_adv_on_full_write : assert property (
    @(posedge clk) disable iff (rst) (w_en && full) |=> $stable(w_ptr_reg));
  a_no_adv_on_empty_read : assert property (
    @(posedge clk) disable iff (rst) (r_en && empty) |=> $stable(r_ptr_reg));
`endif

endmodule

// File: tb/tb_synchronous_fifo.sv
// Randomised bench for synchronous_fifo against a queue-based reference model.
module tb_synchronous_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_dout = '0;

  synchronous_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en),
    .data_in(data_in), .data_out(data_out), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus and advance the reference model by the same edge.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    bit rd;
    bit wr;
    w_en = w;
    r_en = r;
    data_in = d;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_dout = '0;
    end else begin
      rd = r && (exp_q.size() != 0);
      wr = w && (exp_q.size() != DEPTH);
      if (rd) exp_dout = exp_q.pop_front();
      if (wr) exp_q.push_back(d);
    end
    #1;
    $display("txn t=%0t rst=%b w=%b r=%b din=%h -> dout=%h full=%b empty=%b",
             $time, rst, w, r, d, data_out, full, empty);
  endtask

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (check_en) begin
      vectors++;
      if (data_out !== exp_dout || empty !== (exp_q.size() == 0) ||
          full !== (exp_q.size() == DEPTH)) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t data_out=%h exp=%h empty=%b exp=%b full=%b exp=%b",
                 $time, data_out, exp_dout, empty, (exp_q.size() == 0),
                 full, (exp_q.size() == DEPTH));
      end
    end
  end

  initial begin
    // 1. Reset held for 10 clocks while enables toggle.
    rst = 1'b1;
    for (int i = 0; i < 10; i++) step(1'($urandom), 1'($urandom), 8'($urandom));
    check_en = 1'b1;
    check("reset_empty", {7'b0, empty}, 8'h01);
    check("reset_full", {7'b0, full}, 8'h00);
    check("reset_dout", data_out, 8'h00);
    rst = 1'b0;

    // 2. Fill to full, attempt an overflow write, then drain in order.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i * 8'h11));
    check("fill_full", {7'b0, full}, 8'h01);
    step(1'b1, 1'b0, 8'h99);
    check("overflow_full", {7'b0, full}, 8'h01);
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00);
      check("drain_data", data_out, 8'(i * 8'h11));
    end
    check("drain_empty", {7'b0, empty}, 8'h01);

    // 3. Reads while empty change nothing.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'($urandom));
    check("empty_read_dout", data_out, 8'h88);
    check("empty_read_empty", {7'b0, empty}, 8'h01);

    // 4. Writes on even cycles, reads on even cycles starting 10 clocks later.
    for (int c = 0; c < 70; c++)
      step(1'(c < 60 && c % 2 == 0), 1'(c >= 10 && c % 2 == 0), 8'($urandom));
    while (exp_q.size() != 0) step(1'b0, 1'b1, 8'h00);

    // 5. Simultaneous read/write at count 4, at full and at empty.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'($urandom));
    check("simul_mid_full", {7'b0, full}, 8'h00);
    check("simul_mid_empty", {7'b0, empty}, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'($urandom));
    check("simul_pre_full", {7'b0, full}, 8'h01);
    step(1'b1, 1'b1, 8'h5A);
    check("simul_at_full", {7'b0, full}, 8'h00);
    while (exp_q.size() != 0) step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b1, 8'h3C);
    check("simul_at_empty", {7'b0, empty}, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    check("simul_empty_data", data_out, 8'h3C);

    // 6. Reset with 5 words stored discards them.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'($urandom));
    rst = 1'b1;
    step(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    check("midrst_empty", {7'b0, empty}, 8'h01);
    check("midrst_dout", data_out, 8'h00);
    step(1'b1, 1'b0, 8'hA5);
    step(1'b0, 1'b1, 8'h00);
    check("midrst_readback", data_out, 8'hA5);

    // Random traffic to finish.
    for (int i = 0; i < 200; i++) step(1'($urandom), 1'($urandom), 8'($urandom));

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
